// File: rtl/uart_tx_tick.sv
// Tick-paced UART transmitter: start bit, DBIT data bits LSB-first, optional parity, stop.
// The tx line is registered from the next-state line value, so it moves with the state register.
module uart_tx_tick #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int SMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            par_reg, par_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    par_next   = par_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          state_next = START;
          s_next     = '0;
          b_next     = din;
          par_next   = (^din) ^ (PARITY_ODD != 0);
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == SW'(15)) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == SW'(15)) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == NW'(DBIT - 1))
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            else
              n_next = n_reg + NW'(1);
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_reg == SW'(15)) begin
            state_next = STOP;
            s_next     = '0;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == SW'(SB_TICK - 1)) begin
            state_next = IDLE;
            s_next     = '0;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line value follows the state being entered, using the shift register as it will be loaded.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PARITY:  tx_next = par_next;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_ready     = (state_reg == IDLE);
  assign tx_done_tick = done_reg;
  assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed bench for uart_tx_tick: expected frame bits are queued at send time and
// popped when the line is sampled mid-bit, counted in s_ticks since the accept edge.
module tb_uart_tx_tick;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       tick_en;
  logic [1:0] div;
  logic [7:0] din;
  logic [3:0] start_v, tx_v, ready_v, done_v;

  int tests = 0;
  int fails = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!tick_en) begin
      s_tick <= 1'b0;
    end else begin
      div    <= div + 2'd1;
      s_tick <= (div == 2'd3);
    end
  end

  uart_tx_tick #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[0]), .din(din),
    .tx_ready(ready_v[0]), .tx_done_tick(done_v[0]), .tx(tx_v[0]));
  uart_tx_tick #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[1]), .din(din),
    .tx_ready(ready_v[1]), .tx_done_tick(done_v[1]), .tx(tx_v[1]));
  uart_tx_tick #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[2]), .din(din),
    .tx_ready(ready_v[2]), .tx_done_tick(done_v[2]), .tx(tx_v[2]));
  uart_tx_tick #(.DBIT(7), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[3]), .din(din[6:0]),
    .tx_ready(ready_v[3]), .tx_done_tick(done_v[3]), .tx(tx_v[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] data, input int nbits, input int par_en,
                            input int par_odd);
    logic p;
    p = (par_odd != 0);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(data[i]);
      p = p ^ data[i];
    end
    if (par_en != 0) exp_q.push_back(p);
    exp_q.push_back(1'b1);
  endtask

  // Called #1 after the accept edge; returns #1 after the edge that raises tx_done_tick.
  task automatic monitor_frame(input int idx, input int nbits, input int par_en, input int sb,
                               input int freeze_at, input string tag);
    int   total, ticks, slot, nslots, budget;
    bit   seen, frozen_bad;
    logic tx_snap;
    logic [4:0] s_snap;
    logic [3:0] n_snap;
    total  = 16 * (1 + nbits + par_en) + sb;
    nslots = 2 + nbits + par_en;
    budget = total * 8 + 500;
    ticks  = 0;
    slot   = 0;
    seen   = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk);
      if (s_tick) ticks++;
      #1;
      if (slot < nslots && ticks == 16 * slot + 8) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s_sb_empty", tag), 32'd0, 32'd1);
        end else begin
          check($sformatf("%s_bit%0d", tag, slot), {31'd0, tx_v[idx]}, {31'd0, exp_q.pop_front()});
        end
        slot++;
      end
      if (freeze_at > 0 && ticks == freeze_at) begin
        tick_en    = 1'b0;
        frozen_bad = 1'b0;
        @(posedge clk);
        #1;
        tx_snap = tx_v[idx];
        s_snap  = 5'(u0.s_reg);
        n_snap  = 4'(u0.n_reg);
        repeat (100) begin
          @(posedge clk);
          if (s_tick) ticks++;
          #1;
          if (tx_v[idx] !== tx_snap || ready_v[idx] !== 1'b0 || done_v[idx] !== 1'b0 ||
              5'(u0.s_reg) !== s_snap || 4'(u0.n_reg) !== n_snap)
            frozen_bad = 1'b1;
        end
        check($sformatf("%s_frozen", tag), {31'd0, frozen_bad}, 32'd0);
        tick_en   = 1'b1;
        freeze_at = 0;
      end
      if (done_v[idx] === 1'b1) begin
        seen = 1'b1;
        check($sformatf("%s_done_ticks", tag), ticks, total);
        check($sformatf("%s_done_tx", tag), {31'd0, tx_v[idx]}, 32'd1);
        check($sformatf("%s_done_ready", tag), {31'd0, ready_v[idx]}, 32'd1);
      end
    end
    check($sformatf("%s_done_seen", tag), {31'd0, seen}, 32'd1);
    check($sformatf("%s_bits_sampled", tag), slot, nslots);
  endtask

  task automatic send(input int idx, input logic [7:0] data, input int nbits, input int par_en,
                      input int par_odd, input int sb, input int freeze_at, input string tag);
    int w;
    w = 0;
    while (ready_v[idx] !== 1'b1 && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check($sformatf("%s_ready_before", tag), {31'd0, ready_v[idx]}, 32'd1);
    @(negedge clk);
    din          = data;
    start_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_v[idx] = 1'b0;
    check($sformatf("%s_start_tx", tag), {31'd0, tx_v[idx]}, 32'd0);
    check($sformatf("%s_busy", tag), {31'd0, ready_v[idx]}, 32'd0);
    push_frame(data, nbits, par_en, par_odd);
    monitor_frame(idx, nbits, par_en, sb, freeze_at, tag);
  endtask

  task automatic idle_check(input int idx, input int n, input string tag);
    bit bad;
    bad = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done_v[idx] !== 1'b0 || tx_v[idx] !== 1'b1 || ready_v[idx] !== 1'b1) bad = 1'b1;
    end
    check(tag, {31'd0, bad}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int  w;
    bit  done_bad;
    reset   = 1'b1;
    tick_en = 1'b1;
    div     = 2'd0;
    s_tick  = 1'b0;
    din     = 8'h00;
    start_v = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {28'd0, tx_v}, 32'hF);
    check("rst_ready", {28'd0, ready_v}, 32'hF);
    check("rst_done", {28'd0, done_v}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // T1: reset asserted mid-DATA aborts the frame.
    @(negedge clk);
    din        = 8'h5A;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    w = 0;
    while (w < 60) begin
      @(posedge clk);
      if (s_tick) w++;
    end
    #1;
    check("t1_busy_mid_data", {31'd0, ready_v[0]}, 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    done_bad = 1'b0;
    @(posedge clk);
    #1;
    check("t1_tx_next_cycle", {31'd0, tx_v[0]}, 32'd1);
    check("t1_ready_next_cycle", {31'd0, ready_v[0]}, 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done_v[0] !== 1'b0) done_bad = 1'b1;
    end
    check("t1_s_zero", 32'(u0.s_reg), 32'd0);
    check("t1_n_zero", 32'(u0.n_reg), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("t1_no_done_in_reset", {31'd0, done_bad}, 32'd0);
    idle_check(0, 100, "t1_idle_after_reset");

    // T2: default frame, 0xA5.
    send(0, 8'hA5, 8, 0, 0, 16, 0, "t2");
    idle_check(0, 80, "t2_single_done");

    // T3: even and odd parity.
    send(1, 8'hA5, 8, 1, 0, 16, 0, "t3e");
    idle_check(1, 40, "t3e_single_done");
    send(2, 8'hA5, 8, 1, 1, 16, 0, "t3o");
    idle_check(2, 40, "t3o_single_done");

    // T4: tx_start held high, back-to-back frames, din changed after accept.
    @(negedge clk);
    din        = 8'h11;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    check("t4a_start_tx", {31'd0, tx_v[0]}, 32'd0);
    din = 8'h22;
    push_frame(8'h11, 8, 0, 0);
    monitor_frame(0, 8, 0, 16, 0, "t4a");
    @(posedge clk);
    #1;
    check("t4b_no_gap_tx", {31'd0, tx_v[0]}, 32'd0);
    check("t4b_no_gap_busy", {31'd0, ready_v[0]}, 32'd0);
    start_v[0] = 1'b0;
    push_frame(8'h22, 8, 0, 0);
    monitor_frame(0, 8, 0, 16, 0, "t4b");
    idle_check(0, 300, "t4_exactly_two");

    // T5: 7 data bits, two stop bits.
    send(3, 8'h7F, 7, 0, 0, 32, 0, "t5");
    idle_check(3, 60, "t5_single_done");

    // T6: ticks stopped for 100 clocks mid-DATA.
    send(0, 8'h3C, 8, 0, 0, 16, 16 * 3 + 4, "t6");
    idle_check(0, 40, "t6_single_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
